// File: rtl/clock_pkg.sv
// Shared types and constants for the HH:MM:SS timekeeper: FSM states,
// field-select codes, BCD digit type and per-field limits.
package clock_pkg;

  typedef logic [1:0] state_t;
  localparam state_t ST_RUN    = 2'b00;
  localparam state_t ST_SET_HH = 2'b01;
  localparam state_t ST_SET_MM = 2'b10;

  typedef logic [1:0] field_t;
  localparam field_t FIELD_RUN     = 2'b00;
  localparam field_t FIELD_HOURS   = 2'b01;
  localparam field_t FIELD_MINUTES = 2'b10;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HR24_MAX = 8'h23;
  localparam logic [7:0] HR12_MAX = 8'h12;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and rising-edge
// detector producing a one-cycle press event.
module btn_debounce #(
  parameter int DB_CYCLES = 1000,
  parameter int DB_W      = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam logic [DB_W-1:0] COUNT_LAST = DB_W'(DB_CYCLES - 1);

  logic            sync_a;
  logic            sync_b;
  logic            level;
  logic            level_d;
  logic [DB_W-1:0] count;

  // The accepted level only flips after DB_CYCLES consecutive disagreeing samples;
  // any agreeing sample in between restarts the count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_a  <= 1'b0;
      sync_b  <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      count   <= '0;
    end else begin
      sync_a  <= raw;
      sync_b  <= sync_a;
      level_d <= level;
      if (sync_b == level) begin
        count <= '0;
      end else if (count == COUNT_LAST) begin
        level <= sync_b;
        count <= '0;
      end else begin
        count <= count + DB_W'(1);
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/clock_timekeeper.sv
// BCD time-of-day counter with MODE/INC button setting, feeding the
// 7-segment display stage with packed digits and a blink field select.
module clock_timekeeper
  import clock_pkg::*;
#(
  parameter int DB_CYCLES = 1000,
  parameter int DB_W      = 10,
  parameter bit HOUR_24   = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick_1hz,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [23:0] time_bcd,
  output logic [1:0]  field_sel,
  output logic        sec_pulse
);

  localparam logic [7:0] HR_MAX   = HOUR_24 ? HR24_MAX : HR12_MAX;
  localparam logic [7:0] HR_WRAP  = HOUR_24 ? 8'h00 : 8'h01;
  localparam logic [7:0] HR_RESET = HOUR_24 ? 8'h00 : 8'h12;

  // Wrap is decided on the whole field before touching the digits, so a tens
  // digit can never exceed the field limit.
  function automatic logic [7:0] bcd_inc(input logic [7:0] value,
                                         input logic [7:0] max_value,
                                         input logic [7:0] wrap_value);
    bcd_digit_t tens;
    bcd_digit_t ones;
    tens = value[7:4];
    ones = value[3:0];
    if (value == max_value) begin
      return wrap_value;
    end else if (ones == 4'd9) begin
      tens = tens + 4'd1;
      return {tens, 4'd0};
    end else begin
      ones = ones + 4'd1;
      return {tens, ones};
    end
  endfunction

  logic       mode_ev;
  logic       inc_ev;
  state_t     state;
  logic [7:0] hours;
  logic [7:0] minutes;
  logic [7:0] seconds;

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_mode (
    .clock (clock),
    .reset (reset),
    .raw   (btn_mode),
    .press (mode_ev)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_W(DB_W)) u_db_inc (
    .clock (clock),
    .reset (reset),
    .raw   (btn_inc),
    .press (inc_ev)
  );

  // Priority: mode event, then tick (RUN only), then inc (set states only).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_RUN;
      hours     <= HR_RESET;
      minutes   <= 8'h00;
      seconds   <= 8'h00;
      sec_pulse <= 1'b0;
    end else begin
      sec_pulse <= 1'b0;
      if (mode_ev) begin
        case (state)
          ST_RUN:    state <= ST_SET_HH;
          ST_SET_HH: state <= ST_SET_MM;
          default: begin
            state   <= ST_RUN;
            seconds <= 8'h00;
          end
        endcase
      end else if (state == ST_RUN && tick_1hz) begin
        sec_pulse <= 1'b1;
        seconds   <= bcd_inc(seconds, SEC_MAX, 8'h00);
        if (seconds == SEC_MAX) begin
          minutes <= bcd_inc(minutes, MIN_MAX, 8'h00);
          if (minutes == MIN_MAX) begin
            hours <= bcd_inc(hours, HR_MAX, HR_WRAP);
          end
        end
      end else if (inc_ev) begin
        if (state == ST_SET_HH) begin
          hours <= bcd_inc(hours, HR_MAX, HR_WRAP);
        end else if (state == ST_SET_MM) begin
          minutes <= bcd_inc(minutes, MIN_MAX, 8'h00);
        end
      end
    end
  end

  assign time_bcd  = {hours, minutes, seconds};
  assign field_sel = field_t'(state);

endmodule

// File: tb/tb_clock_timekeeper.sv
// Directed bench for clock_timekeeper: a 24 h and a 12 h instance, both with
// an 8-cycle debounce so button sequences stay short.
module tb_clock_timekeeper;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        tick_1hz = 1'b0;
  logic        mode24 = 1'b0, inc24 = 1'b0, mode12 = 1'b0, inc12 = 1'b0;
  logic [23:0] time24, time12;
  logic [1:0]  fs24, fs12;
  logic        sp24, sp12;
  int          checks = 0;
  int          fails = 0;

  always #5 clock = ~clock;

  clock_timekeeper #(.DB_CYCLES(8), .DB_W(4), .HOUR_24(1'b1)) dut24 (
    .clock(clock), .reset(reset), .tick_1hz(tick_1hz), .btn_mode(mode24),
    .btn_inc(inc24), .time_bcd(time24), .field_sel(fs24), .sec_pulse(sp24)
  );

  clock_timekeeper #(.DB_CYCLES(8), .DB_W(4), .HOUR_24(1'b0)) dut12 (
    .clock(clock), .reset(reset), .tick_1hz(tick_1hz), .btn_mode(mode12),
    .btn_inc(inc12), .time_bcd(time12), .field_sel(fs12), .sec_pulse(sp12)
  );

  // sel: 0 = mode24, 1 = inc24, 2 = mode12, 3 = inc12
  task automatic set_btn(input int sel, input logic value);
    case (sel)
      0: mode24 = value;
      1: inc24  = value;
      2: mode12 = value;
      default: inc12 = value;
    endcase
  endtask

  task automatic press(input int sel, input int count);
    for (int i = 0; i < count; i++) begin
      set_btn(sel, 1'b1);
      repeat (12) @(negedge clock);
      set_btn(sel, 1'b0);
      repeat (12) @(negedge clock);
    end
  endtask

  task automatic tick(input int count);
    for (int i = 0; i < count; i++) begin
      tick_1hz = 1'b1;
      @(negedge clock);
      tick_1hz = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (time24 !== 24'h000000) begin fails++; $display("[TB] FAIL reset_low_time24: got %h want 000000", time24); end
    checks++; if (fs24 !== 2'b00 || sp24 !== 1'b0) begin fails++; $display("[TB] FAIL reset_low_ctrl24: fs=%b sp=%b want 00 0", fs24, sp24); end
    checks++; if (time12 !== 24'h120000) begin fails++; $display("[TB] FAIL reset_low_time12: got %h want 120000", time12); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (time24 !== 24'h000000 || fs24 !== 2'b00 || sp24 !== 1'b0) begin fails++; $display("[TB] FAIL reset_release24: t=%h fs=%b sp=%b want 000000 00 0", time24, fs24, sp24); end
  endtask

  task automatic test_set_flow();
    press(0, 1);
    checks++; if (fs24 !== 2'b01) begin fails++; $display("[TB] FAIL set_fs_hours: got %b want 01", fs24); end
    press(1, 3);
    checks++; if (time24 !== 24'h030000) begin fails++; $display("[TB] FAIL set_hours: got %h want 030000", time24); end
    tick_1hz = 1'b1;
    @(negedge clock);
    checks++; if (sp24 !== 1'b0) begin fails++; $display("[TB] FAIL set_tick_pulse: got %b want 0", sp24); end
    tick_1hz = 1'b0;
    tick(3);
    checks++; if (time24 !== 24'h030000) begin fails++; $display("[TB] FAIL set_tick_frozen: got %h want 030000", time24); end
    press(0, 1);
    checks++; if (fs24 !== 2'b10) begin fails++; $display("[TB] FAIL set_fs_minutes: got %b want 10", fs24); end
    press(1, 61);
    checks++; if (time24 !== 24'h030100) begin fails++; $display("[TB] FAIL set_minutes_nocarry: got %h want 030100", time24); end
    press(0, 1);
    checks++; if (fs24 !== 2'b00 || time24 !== 24'h030100) begin fails++; $display("[TB] FAIL set_exit: fs=%b t=%h want 00 030100", fs24, time24); end
  endtask

  task automatic test_reset_mid();
    tick(37);
    checks++; if (time24 !== 24'h030137) begin fails++; $display("[TB] FAIL run_count: got %h want 030137", time24); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (time24 !== 24'h000000 || fs24 !== 2'b00 || sp24 !== 1'b0) begin fails++; $display("[TB] FAIL reset_mid_low: t=%h fs=%b sp=%b want 000000 00 0", time24, fs24, sp24); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (time24 !== 24'h000000 || fs24 !== 2'b00 || sp24 !== 1'b0) begin fails++; $display("[TB] FAIL reset_mid_release: t=%h fs=%b sp=%b want 000000 00 0", time24, fs24, sp24); end
  endtask

  task automatic test_debounce();
    press(0, 1);
    inc24 = 1'b1;
    repeat (5) @(negedge clock);
    inc24 = 1'b0;
    repeat (15) @(negedge clock);
    checks++; if (time24 !== 24'h000000) begin fails++; $display("[TB] FAIL glitch_ignored: got %h want 000000", time24); end
    inc24 = 1'b1;
    repeat (10) @(negedge clock);
    checks++; if (time24 !== 24'h000000) begin fails++; $display("[TB] FAIL press_early: got %h want 000000 after 10 cycles", time24); end
    @(negedge clock);
    checks++; if (time24 !== 24'h010000) begin fails++; $display("[TB] FAIL press_latency: got %h want 010000 after 11 cycles", time24); end
    repeat (9) @(negedge clock);
    inc24 = 1'b0;
    repeat (15) @(negedge clock);
    checks++; if (time24 !== 24'h010000) begin fails++; $display("[TB] FAIL press_once: got %h want 010000", time24); end
    press(0, 2);
    checks++; if (fs24 !== 2'b00) begin fails++; $display("[TB] FAIL debounce_back_run: got %b want 00", fs24); end
  endtask

  task automatic test_collisions();
    tick(1);
    mode24 = 1'b1;
    repeat (10) @(negedge clock);
    tick_1hz = 1'b1;
    @(negedge clock);
    tick_1hz = 1'b0;
    checks++; if (fs24 !== 2'b01 || time24 !== 24'h010001 || sp24 !== 1'b0) begin fails++; $display("[TB] FAIL tick_vs_enter: fs=%b t=%h sp=%b want 01 010001 0", fs24, time24, sp24); end
    repeat (2) @(negedge clock);
    mode24 = 1'b0;
    repeat (12) @(negedge clock);
    mode24 = 1'b1;
    inc24  = 1'b1;
    repeat (12) @(negedge clock);
    mode24 = 1'b0;
    inc24  = 1'b0;
    repeat (12) @(negedge clock);
    checks++; if (fs24 !== 2'b10 || time24 !== 24'h010001) begin fails++; $display("[TB] FAIL mode_vs_inc: fs=%b t=%h want 10 010001", fs24, time24); end
    mode24 = 1'b1;
    repeat (10) @(negedge clock);
    tick_1hz = 1'b1;
    @(negedge clock);
    tick_1hz = 1'b0;
    checks++; if (fs24 !== 2'b00 || time24 !== 24'h010000 || sp24 !== 1'b0) begin fails++; $display("[TB] FAIL tick_vs_exit: fs=%b t=%h sp=%b want 00 010000 0", fs24, time24, sp24); end
    repeat (2) @(negedge clock);
    mode24 = 1'b0;
    repeat (12) @(negedge clock);
  endtask

  task automatic test_rollover();
    do_reset();
    press(0, 1);
    press(1, 23);
    press(0, 1);
    press(1, 59);
    press(0, 1);
    tick(58);
    checks++; if (time24 !== 24'h235958) begin fails++; $display("[TB] FAIL roll_setup: got %h want 235958", time24); end
    tick(1);
    checks++; if (time24 !== 24'h235959 || sp24 !== 1'b1) begin fails++; $display("[TB] FAIL roll_first: t=%h sp=%b want 235959 1", time24, sp24); end
    @(negedge clock);
    checks++; if (sp24 !== 1'b0) begin fails++; $display("[TB] FAIL roll_pulse_width: got %b want 0", sp24); end
    tick(1);
    checks++; if (time24 !== 24'h000000 || sp24 !== 1'b1) begin fails++; $display("[TB] FAIL roll_wrap: t=%h sp=%b want 000000 1", time24, sp24); end
  endtask

  task automatic test_hour12();
    do_reset();
    checks++; if (time12 !== 24'h120000) begin fails++; $display("[TB] FAIL h12_reset: got %h want 120000", time12); end
    press(2, 1);
    press(3, 1);
    checks++; if (time12 !== 24'h010000) begin fails++; $display("[TB] FAIL h12_wrap: got %h want 010000", time12); end
    press(3, 8);
    checks++; if (time12 !== 24'h090000) begin fails++; $display("[TB] FAIL h12_nine: got %h want 090000", time12); end
    press(3, 1);
    checks++; if (time12 !== 24'h100000) begin fails++; $display("[TB] FAIL h12_ten: got %h want 100000", time12); end
    press(3, 2);
    press(2, 1);
    press(3, 59);
    press(2, 1);
    tick(59);
    checks++; if (time12 !== 24'h125959) begin fails++; $display("[TB] FAIL h12_setup: got %h want 125959", time12); end
    tick(1);
    checks++; if (time12 !== 24'h010000 || sp12 !== 1'b1) begin fails++; $display("[TB] FAIL h12_roll: t=%h sp=%b want 010000 1", time12, sp12); end
  endtask

  initial begin
    test_reset();
    test_set_flow();
    test_reset_mid();
    test_debounce();
    test_collisions();
    test_rollover();
    test_hour12();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
